id_ex_alu_issue: RTL
====================

Name: id_ex_alu_issue

Overview:
- ID/EX pipeline stage register that drives the EX-stage ALU's operand and control interface.
- Decodes the instruction's opcode/funct into the 4-bit ALU operation code and selects/extends operands.
- Registers the result with stall (hold) and flush (bubble) control.
- Sits between the register file/decode stage and the ALU; one issue per cycle, 1-cycle latency.

Parameters:
- NBITS, 32, datapath width of register data and ALU operands.
- NREG_ADDR, 5, register-address width.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode stage presents a valid instruction.
- in_instr  in  32  instruction word (opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0], imm [15:0]).
- in_rs_data  in  NBITS  register-file value of rs.
- in_rt_data  in  NBITS  register-file value of rt.
- stall  in  1  hold current outputs.
- flush  in  1  replace next contents with a bubble.
- operando_A  out  NBITS  ALU operand A (registered).
- operando_B  out  NBITS  ALU operand B (registered).
- ALU_control  out  4  ALU operation code (registered).
- out_wr_reg  out  NREG_ADDR  destination register: rd for R-type, rt for I-type.
- out_reg_write  out  1  instruction writes the register file (0 for sw/beq/bne/bubble).
- out_valid  out  1  output slot holds a real instruction.
- out_illegal  out  1  unrecognised opcode/funct was issued.

Behaviour:
- Reset (synchronous, active-high, wins over everything): all outputs 0. ALU_control = 4'b0000, out_valid = 0, out_illegal = 0.
- Update priority per edge: reset > flush > stall > load.
- Flush: load bubble: out_valid = 0, out_reg_write = 0, ALU_control = ADD (0000), operands 0, out_wr_reg 0, out_illegal 0. Flush with stall also asserted still bubbles.
- Stall (no flush): all outputs hold their values exactly.
- Load: if in_valid = 0, load bubble (same as flush). Otherwise decode and register; result is visible the cycle after the edge.
- Op codes: ADD 0000, AND 0001, NOR 0010, OR 0011, SLL 0100, SRL 0101, SRA 0110, SUB 0111, XOR 1000, SRAV 1001, SRLV 1010, SLLV 1011, SLT 1100, LUI 1101.
- R-type (opcode 0x00), A = rs_data, B = rt_data unless noted:
  - add/addu (0x20/0x21) ADD; sub/subu (0x22/0x23) SUB.
  - and 0x24 AND; or 0x25 OR; xor 0x26 XOR; nor 0x27 NOR; slt 0x2A SLT.
  - sll/srl/sra (0x00/0x02/0x03): A = rt_data, B = sign-extended imm (shamt lands in B[10:6]).
  - sllv/srlv/srav (0x04/0x06/0x07): A = rt_data, B = {27'b0, rs_data[4:0]}.
- I-type, A = rs_data:
  - addi/addiu 0x08/0x09 ADD, sign-extended imm.
  - slti 0x0A SLT, sign-extended imm.
  - andi/ori/xori 0x0C/0x0D/0x0E AND/OR/XOR, zero-extended imm.
  - lui 0x0F LUI, B = zero-extended imm, A = 0.
  - loads 0x20–0x27 and stores 0x28–0x2B ADD, sign-extended imm; stores have out_reg_write = 0.
  - beq/bne 0x04/0x05 SUB, B = rt_data, out_reg_write = 0.
- Illegal opcode/funct: ALU_control = 4'b1111, out_illegal = 1, out_reg_write = 0, out_valid = 1.
- Sign extension replicates imm[15] into [NBITS-1:16]; zero extension fills with 0.
- Write to register 0 (out_wr_reg = 0) is passed through; suppression is done downstream.

Decomposition:
- Shared header holds the ALU op-code defines (shared with the ALU, single source) and the opcode/funct constants.
- Sub-module alu_control_decoder: purely combinational; opcode/funct to ALU_control, operand-select, extend-mode, reg_dst, reg_write, illegal.
- The top level holds the operand muxes and the registered stage.

Test Plan:
- Reset: reset = 1 for 2 cycles with random inputs -> all outputs 0, ALU_control = 0000.
- addi: in_instr = addi $2,$1,-4 (0x2022FFFC), rs_data = 10 -> next cycle A = 10, B = 0xFFFFFFFC, ALU_control = 0000, out_wr_reg = 2, out_reg_write = 1.
- Shifts:
  - sll $3,$4,5 (0x00041940), rt_data = 1 -> A = 1, B[10:6] = 5, ALU_control = 0100, out_wr_reg = 3.
  - srav with rs_data = 0x123 -> B = 0x3, ALU_control = 1001.
- Zero-extend and LUI:
  - ori $5,$0,0x8000 -> B = 0x00008000, ALU_control = 0011.
  - lui $6,0xABCD -> B = 0x0000ABCD, ALU_control = 1101.
- Stall/flush sequence: issue add, stall 3 cycles while changing inputs -> outputs frozen; then assert flush and stall together -> bubble (out_valid = 0, out_reg_write = 0, ALU_control = 0000).
- Illegal: opcode 0x3F -> ALU_control = 1111, out_illegal = 1, out_reg_write = 0; next valid instruction clears out_illegal.

Source files
------------

// File: rtl/id_ex_alu_issue_pkg.sv
// Shared ALU op codes, MIPS opcode/funct constants and the decoder output bundle
// used by the ID/EX issue stage and the ALU.
package id_ex_alu_issue_pkg;

  typedef enum logic [3:0] {
    ALU_ADD     = 4'b0000,
    ALU_AND     = 4'b0001,
    ALU_NOR     = 4'b0010,
    ALU_OR      = 4'b0011,
    ALU_SLL     = 4'b0100,
    ALU_SRL     = 4'b0101,
    ALU_SRA     = 4'b0110,
    ALU_SUB     = 4'b0111,
    ALU_XOR     = 4'b1000,
    ALU_SRAV    = 4'b1001,
    ALU_SRLV    = 4'b1010,
    ALU_SLLV    = 4'b1011,
    ALU_SLT     = 4'b1100,
    ALU_LUI     = 4'b1101,
    ALU_ILLEGAL = 4'b1111
  } alu_op_e;

  localparam logic [5:0] OP_RTYPE    = 6'h00;
  localparam logic [5:0] OP_BEQ      = 6'h04;
  localparam logic [5:0] OP_BNE      = 6'h05;
  localparam logic [5:0] OP_ADDI     = 6'h08;
  localparam logic [5:0] OP_ADDIU    = 6'h09;
  localparam logic [5:0] OP_SLTI     = 6'h0A;
  localparam logic [5:0] OP_ANDI     = 6'h0C;
  localparam logic [5:0] OP_ORI      = 6'h0D;
  localparam logic [5:0] OP_XORI     = 6'h0E;
  localparam logic [5:0] OP_LUI      = 6'h0F;
  localparam logic [5:0] OP_LOAD_LO  = 6'h20;
  localparam logic [5:0] OP_STORE_LO = 6'h28;
  localparam logic [5:0] OP_STORE_HI = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [1:0] {SEL_A_RS, SEL_A_RT, SEL_A_ZERO} a_sel_e;
  typedef enum logic [1:0] {SEL_B_RT, SEL_B_IMM, SEL_B_RS_AMT} b_sel_e;

  typedef struct packed {
    alu_op_e alu_op;
    a_sel_e  a_sel;
    b_sel_e  b_sel;
    logic    ext_sign;
    logic    reg_dst_rd;
    logic    reg_write;
    logic    illegal;
  } dec_t;

endpackage

// File: rtl/id_ex_alu_issue_alu_control_decoder.sv
// Combinational opcode/funct decode into ALU op, operand selects, extend mode,
// destination choice, register-write enable and illegal flag.
module alu_control_decoder
  import id_ex_alu_issue_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{alu_op: ALU_ADD, a_sel: SEL_A_RS, b_sel: SEL_B_IMM, ext_sign: 1'b1,
              reg_dst_rd: 1'b0, reg_write: 1'b1, illegal: 1'b0};
    if (opcode_i == OP_RTYPE) begin
      dec_o.reg_dst_rd = 1'b1;
      dec_o.b_sel      = SEL_B_RT;
      case (funct_i)
        FN_ADD, FN_ADDU: dec_o.alu_op = ALU_ADD;
        FN_SUB, FN_SUBU: dec_o.alu_op = ALU_SUB;
        FN_AND:          dec_o.alu_op = ALU_AND;
        FN_OR:           dec_o.alu_op = ALU_OR;
        FN_XOR:          dec_o.alu_op = ALU_XOR;
        FN_NOR:          dec_o.alu_op = ALU_NOR;
        FN_SLT:          dec_o.alu_op = ALU_SLT;
        // Immediate shifts take shamt through the sign-extended imm field.
        FN_SLL, FN_SRL, FN_SRA: begin
          dec_o.a_sel = SEL_A_RT;
          dec_o.b_sel = SEL_B_IMM;
          dec_o.alu_op = (funct_i == FN_SLL) ? ALU_SLL :
                         (funct_i == FN_SRL) ? ALU_SRL : ALU_SRA;
        end
        FN_SLLV, FN_SRLV, FN_SRAV: begin
          dec_o.a_sel = SEL_A_RT;
          dec_o.b_sel = SEL_B_RS_AMT;
          dec_o.alu_op = (funct_i == FN_SLLV) ? ALU_SLLV :
                         (funct_i == FN_SRLV) ? ALU_SRLV : ALU_SRAV;
        end
        default: dec_o.illegal = 1'b1;
      endcase
    end else if (opcode_i >= OP_LOAD_LO && opcode_i <= OP_STORE_HI) begin
      dec_o.alu_op = ALU_ADD;
      if (opcode_i >= OP_STORE_LO) dec_o.reg_write = 1'b0;
    end else begin
      case (opcode_i)
        OP_ADDI, OP_ADDIU: dec_o.alu_op = ALU_ADD;
        OP_SLTI:           dec_o.alu_op = ALU_SLT;
        OP_ANDI: begin dec_o.alu_op = ALU_AND; dec_o.ext_sign = 1'b0; end
        OP_ORI:  begin dec_o.alu_op = ALU_OR;  dec_o.ext_sign = 1'b0; end
        OP_XORI: begin dec_o.alu_op = ALU_XOR; dec_o.ext_sign = 1'b0; end
        OP_LUI: begin
          dec_o.alu_op   = ALU_LUI;
          dec_o.ext_sign = 1'b0;
          dec_o.a_sel    = SEL_A_ZERO;
        end
        OP_BEQ, OP_BNE: begin
          dec_o.alu_op    = ALU_SUB;
          dec_o.b_sel     = SEL_B_RT;
          dec_o.reg_write = 1'b0;
        end
        default: dec_o.illegal = 1'b1;
      endcase
    end
    if (dec_o.illegal) begin
      dec_o.alu_op    = ALU_ILLEGAL;
      dec_o.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX stage register: decodes the issued instruction, builds ALU operands and
// holds them for the EX stage with stall (hold) and flush (bubble) control.
module id_ex_alu_issue
  import id_ex_alu_issue_pkg::*;
#(
  parameter int NBITS     = 32,
  parameter int NREG_ADDR = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [31:0]          in_instr,
  input  logic [NBITS-1:0]     in_rs_data,
  input  logic [NBITS-1:0]     in_rt_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic [NBITS-1:0]     operando_A,
  output logic [NBITS-1:0]     operando_B,
  output logic [3:0]           ALU_control,
  output logic [NREG_ADDR-1:0] out_wr_reg,
  output logic                 out_reg_write,
  output logic                 out_valid,
  output logic                 out_illegal
);

  dec_t dec;
  logic [NBITS-1:0] imm_ext;
  logic [NBITS-1:0] rs_amt;
  logic [NBITS-1:0] op_a;
  logic [NBITS-1:0] op_b;
  logic [4:0]       unused_rs_field;

  logic [NBITS-1:0]     a_q, a_d, b_q, b_d;
  logic [3:0]           alu_q, alu_d;
  logic [NREG_ADDR-1:0] wr_q, wr_d;
  logic                 rw_q, rw_d, valid_q, valid_d, ill_q, ill_d;

  // Register addresses come from the register file side; rs is only consumed there.
  assign unused_rs_field = in_instr[25:21];

  alu_control_decoder u_dec (
    .opcode_i (in_instr[31:26]),
    .funct_i  (in_instr[5:0]),
    .dec_o    (dec)
  );

  assign imm_ext[15:0] = in_instr[15:0];
  generate
    for (genvar gi = 16; gi < NBITS; gi++) begin : g_ext
      assign imm_ext[gi] = dec.ext_sign & in_instr[15];
    end
  endgenerate

  assign rs_amt = {{(NBITS-5){1'b0}}, in_rs_data[4:0]};

  always_comb begin
    case (dec.a_sel)
      SEL_A_RT:   op_a = in_rt_data;
      SEL_A_ZERO: op_a = '0;
      default:    op_a = in_rs_data;
    endcase
    case (dec.b_sel)
      SEL_B_RT:     op_b = in_rt_data;
      SEL_B_RS_AMT: op_b = rs_amt;
      default:      op_b = imm_ext;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    alu_d   = alu_q;
    wr_d    = wr_q;
    rw_d    = rw_q;
    valid_d = valid_q;
    ill_d   = ill_q;
    // Flush beats stall; an empty issue slot loads the same bubble as a flush.
    if (flush || (!stall && !in_valid)) begin
      a_d     = '0;
      b_d     = '0;
      alu_d   = ALU_ADD;
      wr_d    = '0;
      rw_d    = 1'b0;
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (!stall) begin
      a_d     = op_a;
      b_d     = op_b;
      alu_d   = dec.alu_op;
      wr_d    = dec.reg_dst_rd ? NREG_ADDR'(in_instr[15:11]) : NREG_ADDR'(in_instr[20:16]);
      rw_d    = dec.reg_write;
      valid_d = 1'b1;
      ill_d   = dec.illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= ALU_ADD;
      wr_q    <= '0;
      rw_q    <= 1'b0;
      valid_q <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      valid_q <= valid_d;
      ill_q   <= ill_d;
    end
  end

  assign operando_A    = a_q;
  assign operando_B    = b_q;
  assign ALU_control   = alu_q;
  assign out_wr_reg    = wr_q;
  assign out_reg_write = rw_q;
  assign out_valid     = valid_q;
  assign out_illegal   = ill_q;

endmodule
